// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the two-way round-robin arbiter.
//   arb_state_t : grant state (idle / owned by requester 0 / owned by 1)
//   SRC0, SRC1  : requester ids, also the mux select / out_src encoding
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between two producers, the arbiter and one consumer.
//   slave  : arbiter view (takes valids/data/out_ready, drives readies/out beat)
//   master : environment view (the mirror image)
interface mux_rr_arbiter_if #(parameter int N = 4);

    logic         in0_valid;
    logic [N-1:0] in0_data;
    logic         in0_ready;
    logic         in1_valid;
    logic [N-1:0] in1_data;
    logic         in1_ready;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_src;
    logic         out_ready;

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_src
    );

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/mux_rr_arbiter_mux_2x1.sv
// Two-input N-bit data selector.
//   d0, d1 : candidate words
//   sel    : 0 picks d0, 1 picks d1
//   y      : selected word
module mux_2x1 #(
    parameter int N = 4
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic         sel,
    output logic [N-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered N-bit output between two
// valid/ready requesters, limiting an owner to MAX_BURST back-to-back beats
// while the other requester waits.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : in0/in1 valid/data/ready, out valid/data/src/ready
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BURST = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_rr_arbiter_if.slave bus
);

    localparam int            CW   = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    arb_state_t    state;
    logic          last_owner;
    logic [CW-1:0] burst_cnt;
    logic          out_valid_q;
    logic [N-1:0]  out_data_q;
    logic          out_src_q;

    logic          load_en;
    logic          grant_vld;
    logic          grant;
    logic          kept;
    logic          own;
    logic          mine_v;
    logic          oth_v;
    logic [N-1:0]  mux_y;

    assign load_en = !out_valid_q || bus.out_ready;

    // Grant decision from registered state and current valids.
    always_comb begin
        grant_vld = 1'b0;
        grant     = SRC0;
        kept      = 1'b0;
        own       = (state == ARB_OWN1);
        mine_v    = own ? bus.in1_valid : bus.in0_valid;
        oth_v     = own ? bus.in0_valid : bus.in1_valid;
        case (state)
            ARB_OWN0, ARB_OWN1: begin
                // Owner may exceed the burst limit only if nobody is waiting.
                if (mine_v && (burst_cnt < MAXC || !oth_v)) begin
                    grant_vld = 1'b1;
                    grant     = own;
                    kept      = 1'b1;
                end else if (oth_v) begin
                    grant_vld = 1'b1;
                    grant     = ~own;
                end
            end
            default: begin
                if (bus.in0_valid && bus.in1_valid) begin
                    grant_vld = 1'b1;
                    grant     = ~last_owner;
                end else if (bus.in0_valid) begin
                    grant_vld = 1'b1;
                    grant     = SRC0;
                end else if (bus.in1_valid) begin
                    grant_vld = 1'b1;
                    grant     = SRC1;
                end
            end
        endcase
    end

    assign bus.in0_ready = load_en && grant_vld && (grant == SRC0) && bus.in0_valid;
    assign bus.in1_ready = load_en && grant_vld && (grant == SRC1) && bus.in1_valid;

    mux_2x1 #(.N(N)) u_mux (
        .d0  (bus.in0_data),
        .d1  (bus.in1_data),
        .sel (grant),
        .y   (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            last_owner  <= SRC1;
            burst_cnt   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC0;
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mux_y;
                out_src_q   <= grant;
                state       <= grant ? ARB_OWN1 : ARB_OWN0;
                last_owner  <= grant;
                // A kept owner at the limit starts a fresh burst instead of wrapping.
                burst_cnt   <= (kept && burst_cnt != MAXC) ? burst_cnt + CW'(1) : CW'(1);
            end else begin
                out_valid_q <= 1'b0;
                state       <= ARB_IDLE;
                burst_cnt   <= '0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule
